// File: rtl/insight_commit_trace_sink_if.sv
// Commit-port and trace-stream bundle for insight_commit_trace_sink.
// master = core/funnel side, slave = trace sink.
interface insight_commit_trace_sink_if;
  logic        trace_enable;
  logic [31:0] pc;
  logic [31:0] instruction;
  logic        commit;
  logic        exception;
  logic        interrupt_fire;
  logic [2:0]  mode;
  logic        rd_wen;
  logic [4:0]  rd_waddr;
  logic [31:0] rd_wdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;

  modport master (
    output trace_enable, pc, instruction, commit, exception, interrupt_fire,
           mode, rd_wen, rd_waddr, rd_wdata, out_ready,
    input  out_valid, out_data, out_last
  );

  modport slave (
    input  trace_enable, pc, instruction, commit, exception, interrupt_fire,
           mode, rd_wen, rd_waddr, rd_wdata, out_ready,
    output out_valid, out_data, out_last
  );
endinterface

// File: rtl/insight_commit_trace_sink.sv
// Hart-0 commit trace sink: buffers commit events and streams them as 32-bit word packets.
// Define INSIGHT_TRACE_RD_DATA_EN to add a fourth packet word carrying rd_wdata.
module insight_commit_trace_sink #(
  parameter int DEPTH  = 4,
  parameter int DROP_W = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  insight_commit_trace_sink_if.slave port,
  output logic [DROP_W-1:0]         drop_count,
  output logic                      busy
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];
  localparam logic [AW:0] ONE_CNT  = 1;

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_PC, S_INSN, S_RD} state_t;

  logic [23:0] hdr_mem  [DEPTH];
  logic [31:0] pc_mem   [DEPTH];
  logic [31:0] insn_mem [DEPTH];
`ifdef INSIGHT_TRACE_RD_DATA_EN
  logic [31:0] rd_mem   [DEPTH];
`else
  logic        rd_wdata_unused;
  assign rd_wdata_unused = ^port.rd_wdata;
`endif

  state_t            state_reg;
  logic              out_valid_reg;
  logic              out_last_reg;
  logic [31:0]       out_data_reg;
  logic [AW-1:0]     rd_ptr_reg;
  logic [AW-1:0]     wr_ptr_reg;
  logic [AW:0]       count_reg;
  logic [10:0]       seq_reg;
  logic              ovf_reg;
  logic [DROP_W-1:0] drop_count_reg;

  logic          ev, full, push, drop, hs, pop, more;
  logic [23:0]   new_hdr;
  logic [AW-1:0] rd_ptr_inc;
  logic [31:0]   next_hdr_word;

  assign ev         = port.trace_enable & (port.commit | port.exception | port.interrupt_fire);
  // full is the registered occupancy: a pop in this cycle does not make room for this push
  assign full       = (count_reg == FULL_CNT);
  assign push       = ev & ~full;
  assign drop       = ev & full;
  assign hs         = out_valid_reg & port.out_ready;
  assign pop        = hs & out_last_reg;
  assign rd_ptr_inc = rd_ptr_reg + AW'(1);
  assign new_hdr    = {port.mode, port.commit, port.exception, port.interrupt_fire,
                       ovf_reg, port.rd_wen, port.rd_waddr, seq_reg};
  assign more       = (count_reg > ONE_CNT) | push;
  // When the only remaining record is being written this very cycle, forward it directly
  assign next_hdr_word = {8'hA5, (count_reg > ONE_CNT) ? hdr_mem[rd_ptr_inc] : new_hdr};

  always_ff @(posedge clock) begin
    if (push) begin
      hdr_mem[wr_ptr_reg]  <= new_hdr;
      pc_mem[wr_ptr_reg]   <= port.pc;
      insn_mem[wr_ptr_reg] <= port.instruction;
`ifdef INSIGHT_TRACE_RD_DATA_EN
      rd_mem[wr_ptr_reg]   <= port.rd_wen ? port.rd_wdata : 32'h0;
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= S_IDLE;
      out_valid_reg  <= 1'b0;
      out_last_reg   <= 1'b0;
      out_data_reg   <= 32'h0;
      rd_ptr_reg     <= '0;
      wr_ptr_reg     <= '0;
      count_reg      <= '0;
      seq_reg        <= 11'd0;
      ovf_reg        <= 1'b0;
      drop_count_reg <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
        seq_reg    <= seq_reg + 11'd1;
        ovf_reg    <= 1'b0;
      end else if (drop) begin
        ovf_reg <= 1'b1;
        if (drop_count_reg != {DROP_W{1'b1}})
          drop_count_reg <= drop_count_reg + DROP_W'(1);
      end

      if (pop)
        rd_ptr_reg <= rd_ptr_inc;

      case ({push, pop})
        2'b10:   count_reg <= count_reg + ONE_CNT;
        2'b01:   count_reg <= count_reg - ONE_CNT;
        default: ;
      endcase

      if (pop) begin
        if (more) begin
          state_reg    <= S_HDR;
          out_data_reg <= next_hdr_word;
          out_last_reg <= 1'b0;
        end else begin
          state_reg     <= S_IDLE;
          out_valid_reg <= 1'b0;
          out_last_reg  <= 1'b0;
          out_data_reg  <= 32'h0;
        end
      end else begin
        case (state_reg)
          S_IDLE: begin
            if (count_reg != '0) begin
              state_reg     <= S_HDR;
              out_valid_reg <= 1'b1;
              out_last_reg  <= 1'b0;
              out_data_reg  <= {8'hA5, hdr_mem[rd_ptr_reg]};
            end
          end
          S_HDR: begin
            if (hs) begin
              state_reg    <= S_PC;
              out_data_reg <= pc_mem[rd_ptr_reg];
            end
          end
          S_PC: begin
            if (hs) begin
              state_reg    <= S_INSN;
              out_data_reg <= insn_mem[rd_ptr_reg];
`ifdef INSIGHT_TRACE_RD_DATA_EN
              out_last_reg <= 1'b0;
`else
              out_last_reg <= 1'b1;
`endif
            end
          end
          S_INSN: begin
`ifdef INSIGHT_TRACE_RD_DATA_EN
            if (hs) begin
              state_reg    <= S_RD;
              out_data_reg <= rd_mem[rd_ptr_reg];
              out_last_reg <= 1'b1;
            end
`endif
          end
          default: ;
        endcase
      end
    end
  end

  assign port.out_valid = out_valid_reg;
  assign port.out_data  = out_data_reg;
  assign port.out_last  = out_last_reg;
  assign drop_count     = drop_count_reg;
  assign busy           = (count_reg != '0) | (state_reg != S_IDLE);
endmodule

// File: tb/tb_insight_commit_trace_sink.sv
// Bench for insight_commit_trace_sink: directed steps plus a randomized stream checked
// against a record-queue model of the trace packets.
module tb_insight_commit_trace_sink;
  localparam int DEPTH = 4;
`ifdef INSIGHT_TRACE_RD_DATA_EN
  localparam int NW = 4;
`else
  localparam int NW = 3;
`endif

  typedef struct packed {
    logic [31:0] h;
    logic [31:0] p;
    logic [31:0] i;
    logic [31:0] r;
  } rec_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  insight_commit_trace_sink_if tif();
  insight_commit_trace_sink_if sif();
  logic [15:0] drop_count;
  logic        busy;
  logic [1:0]  sat_drop;
  logic        sat_busy;

  insight_commit_trace_sink #(.DEPTH(DEPTH), .DROP_W(16)) dut (
    .clock(clock), .reset(reset), .port(tif), .drop_count(drop_count), .busy(busy));

  insight_commit_trace_sink #(.DEPTH(DEPTH), .DROP_W(2)) dut_sat (
    .clock(clock), .reset(reset), .port(sif), .drop_count(sat_drop), .busy(sat_busy));

  assign sif.trace_enable   = tif.trace_enable;
  assign sif.pc             = tif.pc;
  assign sif.instruction    = tif.instruction;
  assign sif.commit         = tif.commit;
  assign sif.exception      = tif.exception;
  assign sif.interrupt_fire = tif.interrupt_fire;
  assign sif.mode           = tif.mode;
  assign sif.rd_wen         = tif.rd_wen;
  assign sif.rd_waddr       = tif.rd_waddr;
  assign sif.rd_wdata       = tif.rd_wdata;
  assign sif.out_ready      = 1'b0;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: queue of expected packets, occupancy taken as queue size
  rec_t        exp_q[$];
  logic [10:0] m_seq = 11'd0;
  logic        m_ovf = 1'b0;
  int          m_drops = 0;
  int          widx = 0;
  int          sat_ev = 0;
  int          hdr_count = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = 32'h0;
  logic [31:0] last_hdr = 32'h0;
  logic [31:0] hdr_at_2048 = 32'hxxxx_xxxx;
  logic        m_ev, m_full;
  rec_t        m_rec, m_head;
  logic [31:0] m_word;

  always @(negedge clock) begin
    if (reset) begin
      exp_q.delete();
      m_seq = 11'd0; m_ovf = 1'b0; m_drops = 0; widx = 0; sat_ev = 0;
      hdr_count = 0; prev_stall = 1'b0;
    end else begin
      m_full = (exp_q.size() == DEPTH);
      check("busy", 32'(busy), 32'(exp_q.size() != 0));
      check("drop_count", 32'(drop_count), 32'(m_drops));
      if (prev_stall) begin
        check("hold_valid", 32'(tif.out_valid), 32'd1);
        check("hold_data", tif.out_data, prev_data);
      end
      if (tif.out_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_valid", 32'(tif.out_valid), 32'd0);
        end else begin
          m_head = exp_q[0];
          case (widx)
            0:       m_word = m_head.h;
            1:       m_word = m_head.p;
            2:       m_word = m_head.i;
            default: m_word = m_head.r;
          endcase
          check($sformatf("word%0d", widx), tif.out_data, m_word);
          check("last", 32'(tif.out_last), 32'(widx == NW - 1));
          if (tif.out_ready) begin
            if (widx == 0) begin
              last_hdr = tif.out_data;
              if (hdr_count == 2048) hdr_at_2048 = tif.out_data;
              hdr_count++;
            end
            if (widx == NW - 1) begin
              widx = 0;
              void'(exp_q.pop_front());
            end else begin
              widx++;
            end
          end
        end
      end
      prev_stall = tif.out_valid & ~tif.out_ready;
      prev_data  = tif.out_data;
      m_ev = tif.trace_enable & (tif.commit | tif.exception | tif.interrupt_fire);
      if (m_ev) begin
        sat_ev++;
        if (!m_full) begin
          m_rec.h = {8'hA5, tif.mode, tif.commit, tif.exception, tif.interrupt_fire,
                     m_ovf, tif.rd_wen, tif.rd_waddr, m_seq};
          m_rec.p = tif.pc;
          m_rec.i = tif.instruction;
          m_rec.r = tif.rd_wen ? tif.rd_wdata : 32'h0;
          exp_q.push_back(m_rec);
          m_seq = m_seq + 11'd1;
          m_ovf = 1'b0;
        end else begin
          m_drops++;
          m_ovf = 1'b1;
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic set_event(input logic [31:0] pc, input logic [31:0] insn, input logic [2:0] mode,
                           input logic c, input logic e, input logic irq);
    tif.pc = pc; tif.instruction = insn; tif.mode = mode;
    tif.commit = c; tif.exception = e; tif.interrupt_fire = irq;
    tif.rd_wen = 1'($urandom); tif.rd_waddr = 5'($urandom); tif.rd_wdata = $urandom;
  endtask

  task automatic no_event();
    tif.commit = 1'b0; tif.exception = 1'b0; tif.interrupt_fire = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    step();
    while ((busy || tif.out_valid) && n < budget) begin
      step();
      n++;
    end
    check("drain_idle", 32'(busy), 32'd0);
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (!tif.out_valid && n < budget) begin
      step();
      n++;
    end
    check("wait_valid", 32'(tif.out_valid), 32'd1);
  endtask

  int exp_sat;

  initial begin
    tif.trace_enable = 1'b0; tif.out_ready = 1'b0;
    tif.pc = 32'h0; tif.instruction = 32'h0; tif.mode = 3'd0;
    tif.rd_wen = 1'b0; tif.rd_waddr = 5'd0; tif.rd_wdata = 32'h0;
    no_event();
    repeat (3) step();
    reset = 1'b0;

    // Reset state
    check("rst_valid", 32'(tif.out_valid), 32'd0);
    check("rst_last", 32'(tif.out_last), 32'd0);
    check("rst_data", tif.out_data, 32'h0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_drop", 32'(drop_count), 32'd0);

    // Single commit
    tif.trace_enable = 1'b1; tif.out_ready = 1'b1;
    set_event(32'h8000_0000, 32'h0000_0013, 3'b011, 1'b1, 1'b0, 1'b0);
    tif.rd_wen = 1'b0; tif.rd_waddr = 5'd0;
    step();
    no_event();
    drain(50);
    check("t1_hdr", last_hdr, 32'hA570_0000);
    check("t1_count", 32'(hdr_count), 32'd1);

    // Backpressure on the PC word
    tif.out_ready = 1'b0;
    set_event(32'h8000_0004, $urandom, 3'b011, 1'b1, 1'b0, 1'b0);
    step();
    no_event();
    wait_valid(20);
    tif.out_ready = 1'b1;
    step();
    tif.out_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      check("t2_valid", 32'(tif.out_valid), 32'd1);
      check("t2_data", tif.out_data, 32'h8000_0004);
    end
    tif.out_ready = 1'b1;
    drain(50);

    // Overflow: six commits into a four-entry FIFO
    do_reset();
    tif.out_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      set_event($urandom, $urandom, 3'($urandom), 1'b1, 1'b0, 1'b0);
      step();
    end
    no_event();
    step();
    step();
    check("t3_drops", 32'(drop_count), 32'd2);
    check("t3_busy", 32'(busy), 32'd1);
    tif.out_ready = 1'b1;
    drain(100);
    check("t3_pkts", 32'(hdr_count), 32'd4);
    check("t3_seq3", 32'(last_hdr[10:0]), 32'd3);
    set_event($urandom, $urandom, 3'b011, 1'b1, 1'b0, 1'b0);
    step();
    no_event();
    drain(50);
    check("t3_ovf", 32'(last_hdr[17]), 32'd1);
    check("t3_seq4", 32'(last_hdr[10:0]), 32'd4);

    // Exception plus interrupt, no commit, debug mode
    set_event($urandom, $urandom, 3'b100, 1'b0, 1'b1, 1'b1);
    step();
    no_event();
    drain(50);
    check("t4_fields", 32'(last_hdr[23:18]), 32'(6'b100011));

    // Randomized stream through seq wrap, with drops and enable toggling
    do_reset();
    for (int cyc = 0; cyc < 30000 && hdr_count < 2100; cyc++) begin
      tif.trace_enable = ($urandom % 10) != 0;
      set_event($urandom, $urandom, 3'($urandom), 1'($urandom),
                ($urandom % 8) == 0, ($urandom % 8) == 0);
      tif.out_ready = ($urandom % 4) != 0;
      step();
    end
    no_event();
    tif.out_ready = 1'b1;
    drain(200);
    check("t5_reached", 32'(hdr_count >= 2100), 32'd1);
    check("t5_seq_wrap", 32'(hdr_at_2048[10:0]), 32'd0);
    exp_sat = (sat_ev > 4) ? ((sat_ev - 4 > 3) ? 3 : sat_ev - 4) : 0;
    check("t5_sat", 32'(sat_drop), 32'(exp_sat));

    // Reset during the INSN word
    do_reset();
    tif.trace_enable = 1'b1;
    tif.out_ready = 1'b0;
    set_event($urandom, 32'h1234_5678, 3'b011, 1'b1, 1'b0, 1'b0);
    step();
    no_event();
    wait_valid(20);
    tif.out_ready = 1'b1;
    step();
    step();
    tif.out_ready = 1'b0;
    check("t6_insn", tif.out_data, 32'h1234_5678);
    reset = 1'b1;
    step();
    check("t6_valid", 32'(tif.out_valid), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    tif.out_ready = 1'b1;
    set_event($urandom, $urandom, 3'b001, 1'b1, 1'b0, 1'b0);
    step();
    no_event();
    drain(50);
    check("t6_count", 32'(hdr_count), 32'd1);
    check("t6_seq0", 32'(last_hdr[10:0]), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
